ising_run_ctrl: RTL and testbench
=================================

Name: ising_run_ctrl

Overview:
- Run sequencer that sits directly upstream of the Ising core and sampler top level.
- Drives the top level's ising_rstn and consumes its phase output.
- On a start command it executes num_runs independent anneals: hold the core in reset, let it run, capture phase.
- Accumulates per-spin ones counts across runs and presents last_phase plus a majority-vote phase with a done pulse.

Parameters:
N, 3, number of spins (width of phase)
RST_CYCLES, 4, cycles ising_rstn is held low at the start of each run (≥1)
CNT_W, 16, width of num_runs, run_idx and the per-spin ones counters

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
start  input  1  single-cycle start request; ignored while busy
abort  input  1  cancel an in-progress sequence
run_cycles  input  32  cycles the core runs per anneal; latched on start; 0 treated as 1
num_runs  input  CNT_W  anneals per sequence; latched on start
phase  input  N  spin phases from the top-level sampler
ising_rstn  output  1  reset to the top-level Ising block; low = core held in reset
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the sequence completes
run_idx  output  CNT_W  number of runs captured so far in the current sequence
last_phase  output  N  phase captured at the end of the most recent run
vote_phase  output  N  per-spin strict-majority result

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; ones counters, run_idx, last_phase and latched registers cleared.
  - ising_rstn=0, busy=0, done=0, vote_phase=0.
- States: IDLE, RESET, RUN, CAPTURE, FINISH. All outputs are decoded from registered state/regs (no input-to-output combinational paths).
  - ising_rstn=1 only in RUN and CAPTURE.
  - done=1 only in FINISH.
  - busy=1 in every state except IDLE.
- IDLE:
  - start=1 with num_runs≠0: latch run_cycles (0→1) and num_runs; clear ones counters, run_idx and last_phase; rst_cnt=0; go to RESET.
  - start=1 with num_runs=0: clear counters; go straight to FINISH (done pulses next cycle with vote_phase=0).
- RESET: increment rst_cnt; when rst_cnt==RST_CYCLES-1, set run_cnt=0 and go to RUN. This gives exactly RST_CYCLES low cycles.
- RUN: increment run_cnt (32-bit); when run_cnt==run_cycles_l-1, go to CAPTURE. This gives exactly run_cycles_l high cycles before capture.
- CAPTURE (1 cycle, core still running):
  - last_phase<=phase.
  - ones[i]<=ones[i]+phase[i] for each spin i.
  - run_idx<=run_idx+1.
  - If run_idx+1==num_runs_l go to FINISH; else rst_cnt=0 and go to RESET.
- FINISH (1 cycle): done=1; next state IDLE.
- vote_phase[i] = ({ones[i],1'b0} > {1'b0,num_runs_l}), computed at CNT_W+1 bits.
  - Ties resolve to 0.
  - Counters cannot overflow since ones[i] ≤ num_runs.
  - Valid from the FINISH cycle and held until the next accepted start.
- Per-run latency: RST_CYCLES + run_cycles_l + 1 cycles.
- Sequence latency: start sampled at edge k → done high in cycle k + 1 + num_runs·(RST_CYCLES+run_cycles_l+1).
- abort=1 in any non-IDLE state: next state IDLE, no done pulse, ising_rstn=0. Counters, run_idx and last_phase keep their partial values.
- Simultaneous abort and start in IDLE: start wins.
- start while busy: ignored. Changes to run_cycles/num_runs while busy have no effect.
- rstn=0 mid-sequence: immediate return to the reset values listed above.

Test Plan:
- Single run: N=3, RST_CYCLES=4, run_cycles=10, num_runs=1, phase held 3'b101, start at cycle 0 -> ising_rstn low cycles 1–4, high 5–15; done=1 in cycle 16; last_phase=vote_phase=3'b101; run_idx=1.
- Majority: num_runs=3, phase per capture 3'b011, 3'b001, 3'b110 -> ones={1,2,2} (bits 2..0); vote_phase=3'b011; last_phase=3'b110; run_idx=3.
- Tie and zero: num_runs=2, captures 3'b111 then 3'b000 -> vote_phase=3'b000. Then num_runs=0 start -> done in the next cycle, busy high for exactly 1 cycle, vote_phase=3'b000.
- Edge case run_cycles=0 -> behaves as 1: ising_rstn high exactly 2 cycles per run (RUN + CAPTURE).
- Abort mid-RUN of run 2 of 4 -> next cycle busy=0, ising_rstn=0, no done, run_idx=1. A start pulse during the aborted sequence had no effect.
- Sync reset asserted mid-CAPTURE, then a fresh start -> all outputs 0 after reset; the new sequence completes with correct counts, unaffected by prior state.

Source files
------------

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the Ising core: repeated reset/run/capture anneals
// with per-spin ones counting and a strict-majority vote across runs.
module ising_run_ctrl #(
  parameter int N          = 3,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      run_cycles,
  input  logic [CNT_W-1:0] num_runs,
  input  logic [N-1:0]     phase,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] run_idx,
  output logic [N-1:0]     last_phase,
  output logic [N-1:0]     vote_phase
);

  localparam int RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST =
    RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_rst_cnt;
  logic [31:0]      r_run_cnt;
  logic [31:0]      r_run_cycles_l;
  logic [CNT_W-1:0] r_num_runs_l;
  logic [CNT_W-1:0] r_run_idx;
  logic [N-1:0]     r_last_phase;
  logic [CNT_W-1:0] r_ones [N];

  logic [CNT_W-1:0] w_idx_nxt;
  logic [N-1:0]     w_vote;

  assign w_idx_nxt = r_run_idx + CNT_W'(1);

  // Doubling ones avoids a divide: ones > runs/2 without rounding ties up.
  always_comb begin
    w_vote = '0;
    for (int i = 0; i < N; i++) begin
      w_vote[i] = ({r_ones[i], 1'b0} >
                   {1'b0, r_num_runs_l});
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_rst_cnt      <= '0;
      r_run_cnt      <= '0;
      r_run_cycles_l <= '0;
      r_num_runs_l   <= '0;
      r_run_idx      <= '0;
      r_last_phase   <= '0;
      for (int i = 0; i < N; i++) begin
        r_ones[i] <= '0;
      end
    end else if (abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_runs_l   <= num_runs;
            r_run_cycles_l <= (run_cycles == 32'd0) ?
                              32'd1 : run_cycles;
            r_run_idx      <= '0;
            r_last_phase   <= '0;
            r_rst_cnt      <= '0;
            for (int i = 0; i < N; i++) begin
              r_ones[i] <= '0;
            end
            r_state <= (num_runs != '0) ?
                       S_RESET : S_FINISH;
          end
        end
        S_RESET: begin
          r_rst_cnt <= r_rst_cnt + RW'(1);
          if (r_rst_cnt == RST_LAST) begin
            r_run_cnt <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 32'd1;
          if (r_run_cnt == r_run_cycles_l - 32'd1) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_last_phase <= phase;
          r_run_idx    <= w_idx_nxt;
          for (int i = 0; i < N; i++) begin
            r_ones[i] <= r_ones[i] + CNT_W'(phase[i]);
          end
          if (w_idx_nxt == r_num_runs_l) begin
            r_state <= S_FINISH;
          end else begin
            r_rst_cnt <= '0;
            r_state   <= S_RESET;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign ising_rstn = (r_state == S_RUN) ||
                      (r_state == S_CAPTURE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);
  assign run_idx    = r_run_idx;
  assign last_phase = r_last_phase;
  assign vote_phase = w_vote;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: per-cycle reset profile checks plus
// a done-driven scoreboard for latency, last_phase, vote_phase, run_idx.
module tb_ising_run_ctrl;

  localparam int N   = 3;
  localparam int RST = 4;
  localparam int CW  = 16;

  logic          clk = 0;
  logic          rstn, start, abort;
  logic [31:0]   run_cycles;
  logic [CW-1:0] num_runs;
  logic [N-1:0]  phase;
  logic          ising_rstn, busy, done;
  logic [CW-1:0] run_idx;
  logic [N-1:0]  last_phase, vote_phase;

  ising_run_ctrl #(.N(N), .RST_CYCLES(RST), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .run_cycles(run_cycles), .num_runs(num_runs),
    .phase(phase), .ising_rstn(ising_rstn), .busy(busy),
    .done(done), .run_idx(run_idx),
    .last_phase(last_phase), .vote_phase(vote_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] last;
    logic [N-1:0] vote;
    int           idx;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("last_phase", 32'(last_phase), 32'(e.last));
        chk("vote_phase", 32'(vote_phase), 32'(e.vote));
        chk("run_idx", 32'(run_idx), 32'(e.idx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ph holds the phase for run r in bits [3r+2:3r].
  task automatic run_seq(input logic [31:0] rc, input int nr,
                         input logic [11:0] ph,
                         input logic [N-1:0] el,
                         input logic [N-1:0] ev, input int ei);
    int   rce, len, s, r, pos;
    logic bad_r, bad_b;
    exp_t e;
    rce = (rc == 0) ? 1 : int'(rc);
    len = RST + rce + 1;
    bad_r = 0;
    bad_b = 0;
    start = 1;
    run_cycles = rc;
    num_runs = CW'(nr);
    phase = ph[2:0];
    step();
    start = 0;
    s = cyc;
    e.cyc = s + nr * len;
    e.last = el;
    e.vote = ev;
    e.idx = ei;
    sb.push_back(e);
    for (int c = 0; c <= nr * len; c++) begin
      r = c / len;
      pos = c % len;
      if (pos == 0 && r < nr) phase = ph[r*3 +: 3];
      if (ising_rstn !== (c < nr * len && pos >= RST)) bad_r = 1;
      if (busy !== 1'b1) bad_b = 1;
      step();
    end
    chk("rstn_profile_ok", 32'(bad_r), 32'd0);
    chk("busy_profile_ok", 32'(bad_b), 32'd0);
    chk("idle_after_seq", 32'(busy), 32'd0);
    chk("done_consumed", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int   s0;
    logic saw_done;
    rstn = 0;
    start = 0;
    abort = 0;
    run_cycles = 0;
    num_runs = 0;
    phase = 0;
    repeat (3) step();
    chk("rst_ising_rstn", 32'(ising_rstn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vote", 32'(vote_phase), 32'd0);
    chk("rst_run_idx", 32'(run_idx), 32'd0);
    rstn = 1;
    step();

    run_seq(32'd10, 1, 12'b000_000_000_101, 3'b101, 3'b101, 1);
    run_seq(32'd3, 3, 12'b000_110_001_011, 3'b110, 3'b011, 3);
    run_seq(32'd2, 2, 12'b000_000_000_111, 3'b000, 3'b000, 2);
    run_seq(32'd2, 0, 12'b000, 3'b000, 3'b000, 0);
    run_seq(32'd0, 2, 12'b000_000_010_010, 3'b010, 3'b010, 2);

    // Abort during RUN of the second of four runs.
    start = 1;
    run_cycles = 5;
    num_runs = 4;
    phase = 3'b010;
    step();
    start = 0;
    s0 = cyc;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        start = 1;
        num_runs = 1;
        run_cycles = 0;
      end else begin
        start = 0;
      end
      step();
    end
    chk("pre_abort_rstn", 32'(ising_rstn), 32'd1);
    chk("pre_abort_idx", 32'(run_idx), 32'd1);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rstn", 32'(ising_rstn), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_idx", 32'(run_idx), 32'd1);
    chk("abort_last", 32'(last_phase), 32'b010);
    chk("abort_cycle", cyc - s0, 17);
    saw_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) saw_done = 1;
      step();
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // Sync reset while in CAPTURE of the first run.
    start = 1;
    run_cycles = 3;
    num_runs = 2;
    phase = 3'b111;
    step();
    start = 0;
    repeat (7) step();
    chk("pre_rst_capture_rstn", 32'(ising_rstn), 32'd1);
    rstn = 0;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rstn", 32'(ising_rstn), 32'd0);
    chk("mid_rst_idx", 32'(run_idx), 32'd0);
    chk("mid_rst_last", 32'(last_phase), 32'd0);
    chk("mid_rst_vote", 32'(vote_phase), 32'd0);
    rstn = 1;
    step();
    run_seq(32'd2, 3, 12'b000_001_100_100, 3'b001, 3'b100, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
